// File: rtl/block_ram_requester.sv
// block_ram_requester: arbitrates a single-port registered-read RAM between
// client read/write requests and a full zero-fill sequence. Read data is
// returned through a 2-entry response FIFO guarded by a credit check, so a
// read is only issued when its response is guaranteed a slot.
module block_ram_requester #(
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   reqValid,
  output logic                   reqReady,
  input  logic                   reqWrite,
  input  logic [INDEX_WIDTH-1:0] reqIndex,
  input  logic [DATA_WIDTH-1:0]  reqWriteValue,
  output logic                   respValid,
  input  logic                   respReady,
  output logic [DATA_WIDTH-1:0]  respValue,
  input  logic                   clearStart,
  output logic                   clearBusy,
  output logic [INDEX_WIDTH-1:0] ramIndex,
  output logic [DATA_WIDTH-1:0]  ramWriteValue,
  output logic                   ramWriteEnable,
  input  logic [DATA_WIDTH-1:0]  ramReadValue
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [INDEX_WIDTH-1:0] CNT_ONE  = INDEX_WIDTH'(1);
  localparam logic [INDEX_WIDTH-1:0] CNT_LAST = {INDEX_WIDTH{1'b1}};

  // Control state
  state_t                 r_state;
  logic [INDEX_WIDTH-1:0] r_clrCnt;
  logic                   r_rdVld_p1;
  logic                   r_wrPtr;
  logic                   r_rdPtr;
  logic [1:0]             r_fifoCount;

  // Response storage (data only, never reset)
  logic [DATA_WIDTH-1:0]  r_fifoMem [2];

  logic       w_idle;
  logic       w_pop;
  logic       w_push;
  logic [2:0] w_occ;
  logic       w_credit;
  logic       w_accept;
  logic       w_acceptRead;
  logic       w_acceptWrite;

  assign w_idle = (r_state == ST_IDLE);
  assign w_pop  = respValid & respReady;
  assign w_push = r_rdVld_p1;

  // Slots already committed: buffered entries plus the read whose data lands
  // next edge, minus whatever the consumer drains this cycle.
  assign w_occ    = {1'b0, r_fifoCount} + {2'b00, r_rdVld_p1} - {2'b00, w_pop};
  assign w_credit = (w_occ < 3'd2);

  // Gated by rstN so the handshake is silent while reset is held.
  assign reqReady      = rstN & w_idle & ~clearStart & (reqWrite | w_credit);
  assign w_accept      = reqValid & reqReady;
  assign w_acceptRead  = w_accept & ~reqWrite;
  assign w_acceptWrite = w_accept & reqWrite;

  assign clearBusy      = (r_state == ST_CLEAR);
  assign ramIndex       = w_idle ? reqIndex : r_clrCnt;
  assign ramWriteValue  = w_idle ? reqWriteValue : '0;
  assign ramWriteEnable = w_idle ? w_acceptWrite : 1'b1;

  assign respValid = (r_fifoCount != 2'd0);
  assign respValue = r_fifoMem[r_rdPtr];

  // Mode FSM: IDLE serves requests, CLEAR sweeps every index with zero.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state  <= ST_IDLE;
      r_clrCnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clearStart) begin
            r_state  <= ST_CLEAR;
            r_clrCnt <= '0;
          end
        end
        ST_CLEAR: begin
          if (r_clrCnt == CNT_LAST) begin
            r_state  <= ST_IDLE;
            r_clrCnt <= '0;
          end else begin
            r_clrCnt <= r_clrCnt + CNT_ONE;
          end
        end
      endcase
    end
  end

  // Stage p0 -> p1: track the read whose RAM data arrives next cycle, and
  // maintain FIFO pointers/occupancy (push and pop may coincide).
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_rdVld_p1  <= 1'b0;
      r_wrPtr     <= 1'b0;
      r_rdPtr     <= 1'b0;
      r_fifoCount <= 2'd0;
    end else begin
      r_rdVld_p1 <= w_acceptRead;
      if (w_push) begin
        r_wrPtr <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      r_fifoCount <= r_fifoCount + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Stage p1 -> FIFO: capture registered RAM read data into the tail slot.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifoMem[r_wrPtr] <= ramReadValue;
    end
  end

endmodule

// File: tb/tb_block_ram_requester.sv
// Directed bench for block_ram_requester (INDEX_WIDTH=4, DATA_WIDTH=32) with a
// behavioural registered-read RAM attached to the RAM port.
module tb_block_ram_requester;
  localparam int DW = 32;
  localparam int IW = 4;

  logic          clk;
  logic          rstN;
  logic          reqValid;
  logic          reqReady;
  logic          reqWrite;
  logic [IW-1:0] reqIndex;
  logic [DW-1:0] reqWriteValue;
  logic          respValid;
  logic          respReady;
  logic [DW-1:0] respValue;
  logic          clearStart;
  logic          clearBusy;
  logic [IW-1:0] ramIndex;
  logic [DW-1:0] ramWriteValue;
  logic          ramWriteEnable;
  logic [DW-1:0] ramReadValue;

  logic [DW-1:0] ram [16];

  int checks   = 0;
  int failures = 0;

  block_ram_requester #(
    .DATA_WIDTH (DW),
    .INDEX_WIDTH(IW)
  ) dut (
    .clk           (clk),
    .rstN          (rstN),
    .reqValid      (reqValid),
    .reqReady      (reqReady),
    .reqWrite      (reqWrite),
    .reqIndex      (reqIndex),
    .reqWriteValue (reqWriteValue),
    .respValid     (respValid),
    .respReady     (respReady),
    .respValue     (respValue),
    .clearStart    (clearStart),
    .clearBusy     (clearBusy),
    .ramIndex      (ramIndex),
    .ramWriteValue (ramWriteValue),
    .ramWriteEnable(ramWriteEnable),
    .ramReadValue  (ramReadValue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read RAM model
  always @(posedge clk) begin
    if (ramWriteEnable) ram[ramIndex] <= ramWriteValue;
    ramReadValue <= ram[ramIndex];
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic v, input logic w, input logic [IW-1:0] idx,
                           input logic [DW-1:0] val);
    reqValid      = v;
    reqWrite      = w;
    reqIndex      = idx;
    reqWriteValue = val;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 32'hA000_0000 + i;
    ramReadValue = '0;
    rstN       = 1'b0;
    clearStart = 1'b0;
    respReady  = 1'b0;
    drive_req(1'b1, 1'b1, 4'd2, 32'h1111_1111);

    // Reset state, with a write request held to show it is gated off
    @(negedge clk);
    check_eq("rst_reqReady", reqReady, 0);
    check_eq("rst_respValid", respValid, 0);
    check_eq("rst_clearBusy", clearBusy, 0);
    check_eq("rst_ramWE", ramWriteEnable, 0);

    next_cycle();
    rstN = 1'b1;
    drive_req(1'b0, 1'b0, 4'd0, 32'h0);
    @(negedge clk);
    check_eq("post_rst_reqReady", reqReady, 1);
    check_eq("post_rst_respValid", respValid, 0);

    // Write 0xDEADBEEF to index 3, then read it back next cycle
    next_cycle();
    respReady = 1'b1;
    drive_req(1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF);
    @(negedge clk);
    check_eq("wr_reqReady", reqReady, 1);
    check_eq("wr_ramWE", ramWriteEnable, 1);
    check_eq("wr_ramIndex", ramIndex, 3);
    check_eq("wr_ramData", ramWriteValue, 32'hDEAD_BEEF);

    next_cycle();
    drive_req(1'b1, 1'b0, 4'd3, 32'h0);
    @(negedge clk);
    check_eq("rd3_reqReady", reqReady, 1);
    check_eq("rd3_ramWE", ramWriteEnable, 0);

    next_cycle();
    drive_req(1'b0, 1'b0, 4'd0, 32'h0);
    @(negedge clk);
    check_eq("rd3_n1_respValid", respValid, 0);

    next_cycle();
    @(negedge clk);
    check_eq("rd3_n2_respValid", respValid, 1);
    check_eq("rd3_n2_respValue", respValue, 32'hDEAD_BEEF);

    next_cycle();
    @(negedge clk);
    check_eq("rd3_n3_respValid", respValid, 0);

    // Credit stall: reads 1,2,3 with consumer stalled
    next_cycle();
    respReady = 1'b0;
    drive_req(1'b1, 1'b0, 4'd1, 32'h0);
    @(negedge clk);
    check_eq("cr_rd1_ready", reqReady, 1);

    next_cycle();
    drive_req(1'b1, 1'b0, 4'd2, 32'h0);
    @(negedge clk);
    check_eq("cr_rd2_ready", reqReady, 1);

    next_cycle();
    drive_req(1'b1, 1'b0, 4'd3, 32'h0);
    @(negedge clk);
    check_eq("cr_rd3_stall_a", reqReady, 0);

    next_cycle();
    @(negedge clk);
    check_eq("cr_rd3_stall_b", reqReady, 0);
    check_eq("cr_head_valid", respValid, 1);
    check_eq("cr_head_value", respValue, 32'hA000_0001);

    next_cycle();
    respReady = 1'b1;
    @(negedge clk);
    check_eq("cr_rd3_accept", reqReady, 1);
    check_eq("cr_resp1", respValue, 32'hA000_0001);

    next_cycle();
    drive_req(1'b0, 1'b0, 4'd0, 32'h0);
    @(negedge clk);
    check_eq("cr_resp2_valid", respValid, 1);
    check_eq("cr_resp2", respValue, 32'hA000_0002);

    next_cycle();
    @(negedge clk);
    check_eq("cr_resp3_valid", respValid, 1);
    check_eq("cr_resp3", respValue, 32'hDEAD_BEEF);

    next_cycle();
    @(negedge clk);
    check_eq("cr_drained", respValid, 0);

    // Read in flight when clear starts; clearStart beats a same-cycle request
    next_cycle();
    respReady = 1'b0;
    drive_req(1'b1, 1'b0, 4'd5, 32'h0);
    @(negedge clk);
    check_eq("pc_rd5_ready", reqReady, 1);

    next_cycle();
    clearStart = 1'b1;
    drive_req(1'b1, 1'b1, 4'd9, 32'h0000_0055);
    @(negedge clk);
    check_eq("pc_clr_blocks_ready", reqReady, 0);
    check_eq("pc_clr_blocks_we", ramWriteEnable, 0);
    check_eq("pc_clr_busy_pre", clearBusy, 0);

    // Zero-fill sweep: 16 cycles, index 0..15, with a stray clearStart inside
    for (int i = 0; i < 16; i++) begin
      next_cycle();
      clearStart = (i == 3);
      respReady  = 1'b1;
      @(negedge clk);
      check_eq($sformatf("clr%0d_busy", i), clearBusy, 1);
      check_eq($sformatf("clr%0d_we", i), ramWriteEnable, 1);
      check_eq($sformatf("clr%0d_index", i), ramIndex, i);
      check_eq($sformatf("clr%0d_data", i), ramWriteValue, 0);
      check_eq($sformatf("clr%0d_ready", i), reqReady, 0);
      if (i == 0) begin
        check_eq("clr_preclear_valid", respValid, 1);
        check_eq("clr_preclear_value", respValue, 32'hA000_0005);
      end
      if (i == 1) check_eq("clr_preclear_popped", respValid, 0);
    end

    next_cycle();
    clearStart = 1'b0;
    drive_req(1'b0, 1'b1, 4'd0, 32'h0);
    @(negedge clk);
    check_eq("clr_done_busy", clearBusy, 0);
    check_eq("clr_done_we", ramWriteEnable, 0);
    check_eq("clr_done_ready", reqReady, 1);

    // Back-to-back reads after clear, one per cycle, all zero
    next_cycle();
    drive_req(1'b1, 1'b0, 4'd3, 32'h0);
    @(negedge clk);
    check_eq("bb_rd3_ready", reqReady, 1);

    next_cycle();
    drive_req(1'b1, 1'b0, 4'd9, 32'h0);
    @(negedge clk);
    check_eq("bb_rd9_ready", reqReady, 1);

    next_cycle();
    drive_req(1'b1, 1'b0, 4'd10, 32'h0);
    @(negedge clk);
    check_eq("bb_rd10_ready", reqReady, 1);
    check_eq("bb_resp3_valid", respValid, 1);
    check_eq("bb_resp3", respValue, 0);

    next_cycle();
    drive_req(1'b0, 1'b0, 4'd0, 32'h0);
    @(negedge clk);
    check_eq("bb_resp9_valid", respValid, 1);
    check_eq("bb_resp9", respValue, 0);

    next_cycle();
    @(negedge clk);
    check_eq("bb_resp10_valid", respValid, 1);
    check_eq("bb_resp10", respValue, 0);

    next_cycle();
    @(negedge clk);
    check_eq("bb_drained", respValid, 0);

    // Reset in the middle of CLEAR with a buffered response pending
    next_cycle();
    respReady = 1'b0;
    drive_req(1'b1, 1'b0, 4'd1, 32'h0);
    @(negedge clk);
    check_eq("mr_rd1_ready", reqReady, 1);

    next_cycle();
    clearStart = 1'b1;
    drive_req(1'b0, 1'b0, 4'd0, 32'h0);
    @(negedge clk);
    check_eq("mr_clr_ready", reqReady, 0);

    next_cycle();
    clearStart = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      next_cycle();
    end
    @(negedge clk);
    check_eq("mr_cnt7_index", ramIndex, 7);
    check_eq("mr_cnt7_busy", clearBusy, 1);
    check_eq("mr_cnt7_respValid", respValid, 1);
    rstN = 1'b0;
    #1;
    check_eq("mr_rst_busy", clearBusy, 0);
    check_eq("mr_rst_we", ramWriteEnable, 0);
    check_eq("mr_rst_ready", reqReady, 0);
    check_eq("mr_rst_respValid", respValid, 0);

    next_cycle();
    rstN = 1'b1;
    @(negedge clk);
    check_eq("mr_rel_ready", reqReady, 1);
    check_eq("mr_rel_respValid", respValid, 0);
    check_eq("mr_rel_busy", clearBusy, 0);

    next_cycle();
    @(negedge clk);
    check_eq("mr_rel_no_resp", respValid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/block_ram_requester.md
BLOCK_RAM_REQUESTER -- requirements
Module: block_ram_requester

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the RAM word width in bits.
REQ-002 SHALL have parameter INDEX_WIDTH, default 8, the RAM index width; entry count is 2^INDEX_WIDTH.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; all state is clocked on the rising edge of clk and cleared asynchronously when rstN is low.
REQ-004 clk  input  1  clock.
REQ-005 rstN  input  1  asynchronous reset, active low.
REQ-006 reqValid  input  1  request present.
REQ-007 reqReady  output  1  request accepted this cycle when reqValid is also high.
REQ-008 reqWrite  input  1  1 = write, 0 = read.
REQ-009 reqIndex  input  INDEX_WIDTH  request address.
REQ-010 reqWriteValue  input  DATA_WIDTH  write data.
REQ-011 respValid  output  1  read data available.
REQ-012 respReady  input  1  consumer takes the response.
REQ-013 respValue  output  DATA_WIDTH  read data, in request order.
REQ-014 clearStart  input  1  single-cycle pulse that starts a zero-fill of all entries.
REQ-015 clearBusy  output  1  zero-fill in progress.
REQ-016 ramIndex  output  INDEX_WIDTH  RAM port index.
REQ-017 ramWriteValue  output  DATA_WIDTH  RAM port write data.
REQ-018 ramWriteEnable  output  1  RAM port write strobe.
REQ-019 ramReadValue  input  DATA_WIDTH  RAM registered read data; valid one cycle after the index is presented.

Function
REQ-020 SHALL implement states IDLE and CLEAR; IDLE -> CLEAR on clearStart in IDLE; CLEAR -> IDLE after the cycle that writes index 2^INDEX_WIDTH-1.
REQ-021 In IDLE: ramIndex = reqIndex, ramWriteValue = reqWriteValue, and ramWriteEnable = reqValid & reqReady & reqWrite (combinational, same cycle as acceptance).
REQ-022 In CLEAR: ramIndex = clear counter, ramWriteValue = 0, ramWriteEnable = 1 every cycle; the counter starts at 0 and increments by 1, so CLEAR lasts exactly 2^INDEX_WIDTH cycles.
REQ-023 clearBusy SHALL equal (state == CLEAR); clearStart in CLEAR is ignored.
REQ-024 reqReady SHALL be 0 in CLEAR and in any IDLE cycle where clearStart is high; clearStart has priority over a simultaneous request.
REQ-025 A write SHALL be accepted in IDLE with no credit check and SHALL produce no response.
REQ-026 A read SHALL be accepted only if (responseFifoCount + readInFlight - (respValid & respReady)) < 2; the response FIFO holds 2 entries.
REQ-027 A read accepted in cycle N SHALL set readInFlight; in cycle N+1, ramReadValue SHALL be pushed into the response FIFO, with the entry visible at the output from cycle N+2.
REQ-028 respValid = FIFO not empty; respValue = FIFO head; a pop occurs on respValid & respReady; push and pop in the same cycle SHALL both take effect, with the count unchanged.
REQ-029 Back-to-back reads SHALL sustain 1 per cycle while respReady is held high.
REQ-030 A read in flight when CLEAR begins SHALL still be captured, returning pre-clear data; buffered responses SHALL remain deliverable during CLEAR.
REQ-031 Response ordering SHALL equal read acceptance order; a read following a write to the same index in the next cycle SHALL return the new data.

Reset
REQ-032 While rstN is low: state = IDLE, clear counter = 0, readInFlight = 0, FIFO empty; respValid = 0, clearBusy = 0, reqReady = 0, ramWriteEnable = 0.
REQ-033 The first cycle after rstN deasserts SHALL have reqReady = 1 if clearStart is low; reset mid-CLEAR or mid-read SHALL abort the operation with no response produced.

Verification (INDEX_WIDTH=4, DATA_WIDTH=32)
REQ-034 Write 0xDEADBEEF to index 3, then read index 3 with respReady=1 -> respValid high exactly 2 cycles after the read is accepted, respValue=0xDEADBEEF.
REQ-035 Reads of indices 1,2,3 on consecutive cycles with respReady=0 -> the first two are accepted, the third stalls (reqReady=0); after respReady=1, three responses arrive in order 1,2,3.
REQ-036 clearStart pulse -> clearBusy high for exactly 16 cycles, ramWriteEnable high with ramIndex 0..15 and data 0, reqReady=0 throughout; subsequent reads of any index return 0.
REQ-037 Read accepted in the same cycle as... not applicable; read accepted, then clearStart on the next cycle -> the response carries pre-clear data; clearStart held together with reqValid -> request not accepted.
REQ-038 rstN pulled low mid-CLEAR at counter=7 -> all outputs take reset values immediately; after release, reqReady=1 and respValid=0.
